// File: rtl/sipo_pkg.sv
// +----------------------------------------------------------------------------+
// | sipo_pkg                                                                   |
// | Shared types, frame length selection and counter sizing for the SIPO stage |
// | Build option: SIPO_PARITY_EN appends one even-parity bit to every frame.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package sipo_pkg;

`ifdef SIPO_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } sipo_state_t;

  localparam int FRAME_EXTRA = 1;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } sipo_state_t;

  localparam int FRAME_EXTRA = 0;
`endif

  // Number of serial bits in one frame for a given data width.
  function automatic int frame_len(input int width);
    return width + FRAME_EXTRA;
  endfunction

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sipo_out_stage.sv
// +----------------------------------------------------------------------------+
// | sipo_out_stage                                                             |
// | Output holding register with valid/ready handshake and overrun pulse.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sipo_out_stage #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_perr,
  input  logic             out_ready,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             overrun,
  output logic             parity_err
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_over;
  logic             r_perr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_over  <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      r_over <= 1'b0;
      if (load) begin
        // A consume on the same edge frees the register, so no bubble.
        if (!r_valid || out_ready) begin
          r_data  <= load_data;
          r_perr  <= load_perr;
          r_valid <= 1'b1;
        end else begin
          r_over <= 1'b1;
        end
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign parallel_out = r_data;
  assign out_valid    = r_valid;
  assign overrun      = r_over;
  assign parity_err   = r_perr;

endmodule

`default_nettype wire

// File: rtl/sipo_deserializer.sv
// +----------------------------------------------------------------------------+
// | sipo_deserializer                                                          |
// | Serial-in/parallel-out receiver: FSM, bit counter and shift register.      |
// | Build option: SIPO_PARITY_EN adds a trailing even-parity bit per frame.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             serial_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             parity_err
);

  localparam int              c_FRAME     = frame_len(WIDTH);
  localparam int              c_CW        = cnt_w(WIDTH);
  localparam logic [c_CW-1:0] c_LAST      = c_CW'(c_FRAME - 1);
  localparam logic [c_CW-1:0] c_DATA_LAST = c_CW'(WIDTH - 1);

  sipo_state_t      r_state;
  sipo_state_t      w_state_nxt;
  logic [c_CW-1:0]  r_cnt;
  logic [c_CW-1:0]  w_cnt_nxt;
  logic [c_CW-1:0]  w_pos;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_sr_base;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_word;
  logic             w_perr;
  logic             w_data_bit;
  logic             w_complete;

  // A sync bit restarts the frame: it sits at position 0 on an empty register.
  assign w_pos      = sync ? '0 : r_cnt;
  assign w_sr_base  = sync ? '0 : r_sr;
  assign w_complete = serial_valid && (w_pos == c_LAST);

  if (LSB_FIRST) begin : g_lsb_first
    assign w_shifted = {serial_in, w_sr_base[WIDTH-1:1]};
  end else begin : g_msb_first
    assign w_shifted = {w_sr_base[WIDTH-2:0], serial_in};
  end

`ifdef SIPO_PARITY_EN
  assign w_data_bit = (w_pos != c_LAST);
  assign w_word     = r_sr;
  assign w_perr     = ^{r_sr, serial_in};
`else
  assign w_data_bit = 1'b1;
  assign w_word     = w_shifted;
  assign w_perr     = 1'b0;
`endif

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (serial_valid) begin
      w_cnt_nxt = w_complete ? '0 : w_pos + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (serial_valid) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        if (serial_valid && (w_pos == c_DATA_LAST)) begin
`ifdef SIPO_PARITY_EN
          w_state_nxt = PARITY;
`else
          w_state_nxt = IDLE;
`endif
        end
      end
`ifdef SIPO_PARITY_EN
      PARITY: begin
        if (serial_valid) w_state_nxt = sync ? SHIFT : IDLE;
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sr    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (serial_valid && w_data_bit) begin
        r_sr <= w_shifted;
      end
    end
  end

  sipo_out_stage #(
    .WIDTH (WIDTH)
  ) u_out_stage (
    .clk          (clk),
    .rst          (rst),
    .load         (w_complete),
    .load_data    (w_word),
    .load_perr    (w_perr),
    .out_ready    (out_ready),
    .parallel_out (parallel_out),
    .out_valid    (out_valid),
    .overrun      (overrun),
    .parity_err   (parity_err)
  );

endmodule

`default_nettype wire

// File: tb/tb_sipo_deserializer.sv
// +----------------------------------------------------------------------------+
// | tb_sipo_deserializer                                                       |
// | Directed bench for sipo_deserializer (LSB-first and MSB-first instances).  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sipo_deserializer;

  localparam int W = 4;
`ifdef SIPO_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         serial_in = 1'b0;
  logic         serial_valid = 1'b0;
  logic         sync = 1'b0;
  logic         out_ready = 1'b0;

  logic [W-1:0] po_l, po_m;
  logic         ov_l, ov_m, or_l, or_m, pe_l, pe_m;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .serial_in(serial_in), .serial_valid(serial_valid),
    .sync(sync), .parallel_out(po_l), .out_valid(ov_l), .out_ready(out_ready),
    .overrun(or_l), .parity_err(pe_l)
  );

  sipo_deserializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .serial_in(serial_in), .serial_valid(serial_valid),
    .sync(sync), .parallel_out(po_m), .out_valid(ov_m), .out_ready(out_ready),
    .overrun(or_m), .parity_err(pe_m)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collect frame bits in a queue, build the word when full.
  logic         m_bits[$];
  logic [W-1:0] m_word_l = '0, m_word_m = '0;
  logic         m_valid = 1'b0, m_over = 1'b0, m_perr = 1'b0;
  logic         t_done, t_p;
  logic [W-1:0] t_wl, t_wm;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_bits.delete();
      m_word_l = '0; m_word_m = '0;
      m_valid = 1'b0; m_over = 1'b0; m_perr = 1'b0;
    end else begin
      t_done = 1'b0; t_p = 1'b0; t_wl = '0; t_wm = '0;
      if (serial_valid) begin
        if (sync) m_bits.delete();
        m_bits.push_back(serial_in);
        if (m_bits.size() == FRAME) begin
          t_done = 1'b1;
          for (int i = 0; i < FRAME; i++) t_p ^= m_bits[i];
          for (int i = 0; i < W; i++) begin
            t_wl[i]     = m_bits[i];
            t_wm[W-1-i] = m_bits[i];
          end
          m_bits.delete();
        end
      end
      m_over = 1'b0;
      if (t_done) begin
        if (!m_valid || out_ready) begin
          m_word_l = t_wl;
          m_word_m = t_wm;
`ifdef SIPO_PARITY_EN
          m_perr = t_p;
`else
          m_perr = 1'b0;
`endif
          m_valid = 1'b1;
        end else begin
          m_over = 1'b1;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("po_lsb", 32'(po_l), 32'(m_word_l));
    check("po_msb", 32'(po_m), 32'(m_word_m));
    check("valid_lsb", 32'(ov_l), 32'(m_valid));
    check("valid_msb", 32'(ov_m), 32'(m_valid));
    check("overrun_lsb", 32'(or_l), 32'(m_over));
    check("overrun_msb", 32'(or_m), 32'(m_over));
    check("perr_lsb", 32'(pe_l), 32'(m_perr));
    check("perr_msb", 32'(pe_m), 32'(m_perr));
  end

  // All drive tasks start and end on a falling edge.
  task automatic send_bit(input logic b, input logic s);
    serial_in = b; serial_valid = 1'b1; sync = s;
    @(negedge clk);
    serial_valid = 1'b0; sync = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_word(input logic [W-1:0] w, input int gap);
    for (int i = 0; i < W; i++) begin
      send_bit(w[i], 1'b0);
      if (i < W - 1) idle(gap);
    end
`ifdef SIPO_PARITY_EN
    idle(gap);
    send_bit(^w, 1'b0);
`endif
  endtask

  initial begin
    idle(2);
    check("rst_po", 32'(po_l), 32'h0);
    check("rst_valid", 32'(ov_l), 32'h0);
    check("rst_overrun", 32'(or_l), 32'h0);
    rst = 1'b1;
    out_ready = 1'b1;
    idle(1);

    // Reset in the middle of a word
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    send_word(4'b1101, 0);
    check("t1_po", 32'(po_l), 32'hd);
    check("t1_valid", 32'(ov_l), 32'h1);

    // Upstream PISO words, back to back
    send_word(4'b1010, 0);
    check("t2_po_a", 32'(po_l), 32'ha);
    send_word(4'b1111, 0);
    check("t2_po_b", 32'(po_l), 32'hf);
    check("t2_valid", 32'(ov_l), 32'h1);

    // Gapped bits 0,0,1,1
    send_word(4'b1100, 3);
    check("t3_po_lsb", 32'(po_l), 32'hc);
    check("t3_po_msb", 32'(po_m), 32'h3);

    // Stalled consumer
    idle(1);
    out_ready = 1'b0;
    send_word(4'b0101, 0);
    check("t4_valid_a", 32'(ov_l), 32'h1);
    send_word(4'b0110, 0);
    check("t4_overrun", 32'(or_l), 32'h1);
    check("t4_po_held", 32'(po_l), 32'h5);
    idle(1);
    check("t4_overrun_1cyc", 32'(or_l), 32'h0);
    check("t4_valid_b", 32'(ov_l), 32'h1);
    out_ready = 1'b1;
    idle(1);
    check("t4_consumed", 32'(ov_l), 32'h0);
    check("t4_po_kept", 32'(po_l), 32'h5);

    // Partial word then sync
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    check("t5_no_partial", 32'(ov_l), 32'h0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
`ifdef SIPO_PARITY_EN
    send_bit(1'b0, 1'b0);
`endif
    check("t5_po", 32'(po_l), 32'h3);
    check("t5_valid", 32'(ov_l), 32'h1);

`ifdef SIPO_PARITY_EN
    // Data 1011 (sent 1,1,0,1) with good and bad parity bits
    idle(1);
    send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check("t6_po", 32'(po_l), 32'hb);
    check("t6_perr_ok", 32'(pe_l), 32'h0);
    send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    check("t6_perr_bad", 32'(pe_l), 32'h1);
`endif

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
